// File: rtl/lbp_pkg.sv
// Shared types and default image geometry for the LBP address scanner.
package lbp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2
  } dir_t;

  localparam int DEF_IMG_W  = 128;
  localparam int DEF_IMG_H  = 128;
  localparam int DEF_BORDER = 1;

endpackage

// File: rtl/lbp_vote3.sv
// Bitwise 2-of-3 majority voter with a disagreement flag.
module lbp_vote3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y,
  output logic         mismatch
);

  assign y        = (a & b) | (a & c) | (b & c);
  assign mismatch = |((a ^ b) | (a ^ c));

endmodule

// File: rtl/lbp_scan_tmr.sv
// Serpentine/raster LBP address generator with optional triple-redundant address
// state (enabled by defining LBP_SCAN_TMR_TMR_EN).
module lbp_scan_tmr
  import lbp_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int BORDER     = DEF_BORDER,
  parameter int SERPENTINE = 1,
  localparam int CW        = $clog2(IMG_W),
  localparam int RW        = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             lbp_addr_en,
  input  logic             lbp_valid,
  input  logic [2:0]       inj_flip,
  output logic [RW+CW-1:0] lbp_addr,
  output logic             fill_right,
  output logic             fill_down,
  output logic             fill_left,
  output logic             busy,
  output logic             done,
  output logic             tmr_err,
  output logic [7:0]       tmr_err_cnt
);

  localparam int AW     = RW + CW;
  localparam int COL_LO = BORDER;
  localparam int COL_HI = IMG_W - 1 - BORDER;
  localparam int ROW_LO = BORDER;
  localparam int ROW_HI = IMG_H - 1 - BORDER;

  localparam logic [CW-1:0] COL_LO_V = CW'(COL_LO);
  localparam logic [CW-1:0] COL_HI_V = CW'(COL_HI);
  localparam logic [RW-1:0] ROW_LO_V = RW'(ROW_LO);
  localparam logic [RW-1:0] ROW_HI_V = RW'(ROW_HI);
  // An odd number of serpentine row transitions leaves the last row running leftwards.
  localparam logic [CW-1:0] COL_FIN  =
    ((((ROW_HI - ROW_LO) % 2) == 0) || (SERPENTINE == 0)) ? COL_HI_V : COL_LO_V;
  localparam logic [AW-1:0] START_ADDR = {ROW_LO_V, COL_LO_V};

  state_t        state;
  dir_t          dir;
  logic [AW-1:0] voted;
  logic [AW-1:0] step_addr;
  logic [AW-1:0] addr_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          odd_row;
  logic          at_final;
  logic          accept_start;

  assign row          = voted[AW-1:CW];
  assign col          = voted[CW-1:0];
  assign lbp_addr     = voted;
  assign at_final     = (row == ROW_HI_V) && (col == COL_FIN);
  assign accept_start = start && (state != SCAN);

  always_comb begin
    odd_row   = (SERPENTINE != 0) && (row[0] ^ ROW_LO_V[0]);
    dir       = DOWN;
    if (odd_row) begin
      if (col != COL_LO_V) dir = LEFT;
    end else if (col != COL_HI_V) begin
      dir = RIGHT;
    end
    case (dir)
      RIGHT:   step_addr = {row, col + 1'b1};
      LEFT:    step_addr = {row, col - 1'b1};
      default: step_addr = {row + 1'b1, (SERPENTINE != 0) ? col : COL_LO_V};
    endcase
  end

  // Every copy reloads from the voted address each cycle, which scrubs upsets.
  always_comb begin
    addr_nxt = voted;
    if (accept_start) begin
      addr_nxt = START_ADDR;
    end else if ((state == SCAN) && lbp_addr_en && !at_final) begin
      addr_nxt = step_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (lbp_addr_en && at_final) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_right <= 1'b0;
      fill_down  <= 1'b0;
      fill_left  <= 1'b0;
    end else if (lbp_valid) begin
      fill_right <= (dir == RIGHT);
      fill_down  <= (dir == DOWN);
      fill_left  <= (dir == LEFT);
    end
  end

`ifdef LBP_SCAN_TMR_TMR_EN
  logic [AW-1:0] copy_q [3];
  logic [AW-1:0] copy_f [3];
  logic          mismatch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) copy_q[k] <= START_ADDR;
    end else begin
      for (int k = 0; k < 3; k++) copy_q[k] <= addr_nxt;
    end
  end

  // Injected flips sit between the copy registers and the voter/comparator.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      copy_f[k] = copy_q[k] ^ {{(AW-1){1'b0}}, inj_flip[k]};
    end
  end

  lbp_vote3 #(.W(AW)) u_vote (
    .a        (copy_f[0]),
    .b        (copy_f[1]),
    .c        (copy_f[2]),
    .y        (voted),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_err     <= 1'b0;
      tmr_err_cnt <= 8'd0;
    end else begin
      tmr_err <= mismatch;
      if (mismatch && (tmr_err_cnt != 8'hFF)) begin
        tmr_err_cnt <= tmr_err_cnt + 8'd1;
      end
    end
  end
`else
  logic [AW-1:0] addr_q;
  logic          unused_inj;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= START_ADDR;
    end else begin
      addr_q <= addr_nxt;
    end
  end

  assign voted       = addr_q;
  assign tmr_err     = 1'b0;
  assign tmr_err_cnt = 8'd0;
  assign unused_inj  = ^inj_flip;
`endif

endmodule

// File: tb/tb_lbp_scan_tmr.sv
// Directed bench for lbp_scan_tmr: default serpentine scan plus an 8x8 raster instance.
module tb_lbp_scan_tmr;

`ifdef LBP_SCAN_TMR_TMR_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, lbp_addr_en, lbp_valid;
  logic [2:0]  inj_flip;
  logic [13:0] lbp_addr;
  logic        fill_right, fill_down, fill_left, busy, done, tmr_err;
  logic [7:0]  tmr_err_cnt;

  logic        start1, en1;
  logic [2:0]  inj1;
  logic [5:0]  addr1;
  logic        f1_right, f1_down, f1_left, busy1, done1, err1;
  logic [7:0]  cnt1;

  int checks   = 0;
  int failures = 0;
  int n;

  lbp_scan_tmr u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .lbp_addr_en (lbp_addr_en),
    .lbp_valid   (lbp_valid),
    .inj_flip    (inj_flip),
    .lbp_addr    (lbp_addr),
    .fill_right  (fill_right),
    .fill_down   (fill_down),
    .fill_left   (fill_left),
    .busy        (busy),
    .done        (done),
    .tmr_err     (tmr_err),
    .tmr_err_cnt (tmr_err_cnt)
  );

  lbp_scan_tmr #(.IMG_W(8), .IMG_H(8), .BORDER(1), .SERPENTINE(0)) u_ras (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start1),
    .lbp_addr_en (en1),
    .lbp_valid   (lbp_valid),
    .inj_flip    (inj1),
    .lbp_addr    (addr1),
    .fill_right  (f1_right),
    .fill_down   (f1_down),
    .fill_left   (f1_left),
    .busy        (busy1),
    .done        (done1),
    .tmr_err     (err1),
    .tmr_err_cnt (cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; lbp_addr_en = 1'b0; lbp_valid = 1'b0; inj_flip = 3'b000;
    start1 = 1'b0; en1 = 1'b0; inj1 = 3'b000;
    repeat (2) tick();
    chk("rst_addr", lbp_addr, 32'h081);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fill", {fill_right, fill_down, fill_left}, 0);
    chk("rst_err", tmr_err, 0);
    chk("rst_cnt", tmr_err_cnt, 0);
    reset_n = 1'b1;
    tick();

    // lbp_addr_en before start is ignored
    lbp_addr_en = 1'b1; tick(); lbp_addr_en = 1'b0;
    chk("idle_en_ignored", lbp_addr, 32'h081);

    start = 1'b1; tick(); start = 1'b0;
    chk("start_addr", lbp_addr, 32'h081);
    chk("start_busy", busy, 1);

    lbp_addr_en = 1'b1; repeat (125) tick(); lbp_addr_en = 1'b0;
    chk("addr_125", lbp_addr, 32'h0FE);
    lbp_valid = 1'b1; tick(); lbp_valid = 1'b0;
    chk("fill_at_0fe", {fill_right, fill_down, fill_left}, 32'b010);

    start = 1'b1; tick(); start = 1'b0;
    chk("start_in_scan_addr", lbp_addr, 32'h0FE);
    chk("start_in_scan_busy", busy, 1);

    lbp_addr_en = 1'b1; tick();
    chk("addr_down", lbp_addr, 32'h17E);
    tick(); lbp_addr_en = 1'b0;
    chk("addr_left", lbp_addr, 32'h17D);
    lbp_valid = 1'b1; tick(); lbp_valid = 1'b0;
    chk("fill_at_17d", {fill_right, fill_down, fill_left}, 32'b001);

    inj_flip = 3'b010; #1;
    chk("inj1_addr", lbp_addr, 32'h17D);
    tick(); inj_flip = 3'b000;
    chk("inj1_err_pulse", tmr_err, TMR ? 1 : 0);
    chk("inj1_addr_after", lbp_addr, 32'h17D);
    tick();
    chk("inj1_err_clear", tmr_err, 0);
    chk("inj1_cnt", tmr_err_cnt, TMR ? 1 : 0);

    lbp_addr_en = 1'b1; repeat (156) tick(); lbp_addr_en = 1'b0;
    chk("addr_1a0", lbp_addr, 32'h1A0);
    lbp_valid = 1'b1; tick(); lbp_valid = 1'b0;
    chk("fill_at_1a0", {fill_right, fill_down, fill_left}, 32'b100);
    reset_n = 1'b0; tick();
    chk("midrst_addr", lbp_addr, 32'h081);
    chk("midrst_busy", busy, 0);
    chk("midrst_fill", {fill_right, fill_down, fill_left}, 0);
    chk("midrst_cnt", tmr_err_cnt, 0);
    reset_n = 1'b1; tick();

    inj_flip = 3'b111; repeat (300) tick(); inj_flip = 3'b000; tick();
    chk("inj111_cnt", tmr_err_cnt, 0);
    inj_flip = 3'b001; repeat (300) tick();
    chk("inj001_addr", lbp_addr, 32'h081);
    chk("inj001_cnt", tmr_err_cnt, TMR ? 255 : 0);
    inj_flip = 3'b000;
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();

    start = 1'b1; tick(); start = 1'b0;
    lbp_addr_en = 1'b1;
    n = 0;
    while (!done && n < 20000) begin
      tick();
      n++;
    end
    chk("full_accepts", n, 15876);
    chk("full_last_addr", lbp_addr, 32'h3F01);
    chk("full_busy", busy, 0);
    tick();
    lbp_addr_en = 1'b0;
    chk("done_hold_addr", lbp_addr, 32'h3F01);
    chk("done_hold_done", done, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_addr", lbp_addr, 32'h081);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);

    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("ras_start", addr1, 32'h09);
    en1 = 1'b1;
    repeat (5) tick();
    chk("ras_1_6", addr1, 32'h0E);
    tick();
    chk("ras_wrap", addr1, 32'h11);
    n = 6;
    while (!done1 && n < 100) begin
      tick();
      n++;
    end
    en1 = 1'b0;
    chk("ras_accepts", n, 36);
    chk("ras_last", addr1, 32'h36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
